// File: rtl/sequencer_if.sv
// rtl/sequencer_if.sv - control strobes and status between sequencer and datapath/memory
interface sequencer_if #(
  parameter int OP_W = 3
);
  logic            start;
  logic [OP_W-1:0] op;
  logic            z_flag;
  logic            mem_ready;
  logic            PC_bus;
  logic            Addr_bus;
  logic            ACC_bus;
  logic            MDR_bus;
  logic            load_PC;
  logic            INC_PC;
  logic            load_IR;
  logic            load_MAR;
  logic            load_MDR;
  logic            load_ACC;
  logic [1:0]      ALU_op;
  logic            CS;
  logic            R_NW;
  logic            halted;

  modport master (
    input  start, op, z_flag, mem_ready,
    output PC_bus, Addr_bus, ACC_bus, MDR_bus,
    output load_PC, INC_PC, load_IR, load_MAR, load_MDR, load_ACC,
    output ALU_op, CS, R_NW, halted
  );

  modport slave (
    output start, op, z_flag, mem_ready,
    input  PC_bus, Addr_bus, ACC_bus, MDR_bus,
    input  load_PC, INC_PC, load_IR, load_MAR, load_MDR, load_ACC,
    input  ALU_op, CS, R_NW, halted
  );
endinterface

// File: rtl/sequencer.sv
// rtl/sequencer.sv - multi-cycle fetch/decode/execute control FSM with memory wait-states
module sequencer #(
  parameter int OP_W = 3
) (
  input logic        clock,
  input logic        reset,
  sequencer_if.master bus
);
  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_JUMP  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(6);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH0, S_FETCH1, S_DECODE, S_MEM_RD,
    S_EXEC, S_ST_PREP, S_MEM_WR, S_HALTED
  } state_t;

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    bus.PC_bus   = 1'b0;
    bus.Addr_bus = 1'b0;
    bus.ACC_bus  = 1'b0;
    bus.MDR_bus  = 1'b0;
    bus.load_PC  = 1'b0;
    bus.INC_PC   = 1'b0;
    bus.load_IR  = 1'b0;
    bus.load_MAR = 1'b0;
    bus.load_MDR = 1'b0;
    bus.load_ACC = 1'b0;
    bus.ALU_op   = 2'b00;
    bus.CS       = 1'b0;
    bus.R_NW     = 1'b0;
    bus.halted   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FETCH0;
      end
      S_FETCH0: begin
        bus.PC_bus   = 1'b1;
        bus.load_MAR = 1'b1;
        bus.INC_PC   = 1'b1;
        state_d      = S_FETCH1;
      end
      S_FETCH1: begin
        bus.CS      = 1'b1;
        bus.R_NW    = 1'b1;
        bus.load_IR = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Opcode is captured here so EXEC is immune to later IR changes
        op_d = bus.op;
        case (bus.op)
          OP_LOAD, OP_ADD, OP_SUB, OP_XOR: begin
            bus.Addr_bus = 1'b1;
            bus.load_MAR = 1'b1;
            state_d      = S_MEM_RD;
          end
          OP_STORE: begin
            bus.Addr_bus = 1'b1;
            bus.load_MAR = 1'b1;
            state_d      = S_ST_PREP;
          end
          OP_JUMP: begin
            bus.Addr_bus = 1'b1;
            bus.load_PC  = 1'b1;
            state_d      = S_FETCH0;
          end
          OP_BNE: begin
            bus.Addr_bus = !bus.z_flag;
            bus.load_PC  = !bus.z_flag;
            state_d      = S_FETCH0;
          end
          default: state_d = S_HALTED;
        endcase
      end
      S_MEM_RD: begin
        bus.CS       = 1'b1;
        bus.R_NW     = 1'b1;
        bus.load_MDR = bus.mem_ready;
        if (bus.mem_ready) state_d = S_EXEC;
      end
      S_EXEC: begin
        bus.MDR_bus  = 1'b1;
        bus.load_ACC = 1'b1;
        case (op_q)
          OP_ADD:  bus.ALU_op = 2'b01;
          OP_SUB:  bus.ALU_op = 2'b10;
          OP_XOR:  bus.ALU_op = 2'b11;
          default: bus.ALU_op = 2'b00;
        endcase
        state_d = S_FETCH0;
      end
      S_ST_PREP: begin
        bus.ACC_bus  = 1'b1;
        bus.load_MDR = 1'b1;
        state_d      = S_MEM_WR;
      end
      S_MEM_WR: begin
        bus.CS = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH0;
      end
      S_HALTED: begin
        bus.halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_sequencer.sv
// tb/tb_sequencer.sv - directed self-checking bench for the sequencer control FSM
module tb_sequencer;
  logic clock;
  logic reset;
  int   total;
  int   bad;

  sequencer_if #(.OP_W(3)) sif ();

  sequencer #(.OP_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (sif.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Packed view of every output, MSB first
  logic [14:0] outs;
  assign outs = {sif.PC_bus, sif.Addr_bus, sif.ACC_bus, sif.MDR_bus,
                 sif.load_PC, sif.INC_PC, sif.load_IR, sif.load_MAR,
                 sif.load_MDR, sif.load_ACC, sif.ALU_op, sif.CS, sif.R_NW, sif.halted};

  localparam logic [14:0] B_PC_BUS   = 15'd1 << 14;
  localparam logic [14:0] B_ADDR_BUS = 15'd1 << 13;
  localparam logic [14:0] B_ACC_BUS  = 15'd1 << 12;
  localparam logic [14:0] B_MDR_BUS  = 15'd1 << 11;
  localparam logic [14:0] B_LOAD_PC  = 15'd1 << 10;
  localparam logic [14:0] B_INC_PC   = 15'd1 << 9;
  localparam logic [14:0] B_LOAD_IR  = 15'd1 << 8;
  localparam logic [14:0] B_LOAD_MAR = 15'd1 << 7;
  localparam logic [14:0] B_LOAD_MDR = 15'd1 << 6;
  localparam logic [14:0] B_LOAD_ACC = 15'd1 << 5;
  localparam logic [14:0] B_CS       = 15'd1 << 2;
  localparam logic [14:0] B_R_NW     = 15'd1 << 1;
  localparam logic [14:0] B_HALTED   = 15'd1;

  localparam logic [14:0] E_NONE    = 15'd0;
  localparam logic [14:0] E_F0      = B_PC_BUS | B_LOAD_MAR | B_INC_PC;
  localparam logic [14:0] E_RD_WAIT = B_CS | B_R_NW;
  localparam logic [14:0] E_F1_RDY  = B_CS | B_R_NW | B_LOAD_IR;
  localparam logic [14:0] E_RD_RDY  = B_CS | B_R_NW | B_LOAD_MDR;
  localparam logic [14:0] E_DEC_MEM = B_ADDR_BUS | B_LOAD_MAR;
  localparam logic [14:0] E_DEC_JMP = B_ADDR_BUS | B_LOAD_PC;
  localparam logic [14:0] E_EX_LOAD = B_MDR_BUS | B_LOAD_ACC | (15'd0 << 3);
  localparam logic [14:0] E_EX_ADD  = B_MDR_BUS | B_LOAD_ACC | (15'd1 << 3);
  localparam logic [14:0] E_EX_SUB  = B_MDR_BUS | B_LOAD_ACC | (15'd2 << 3);
  localparam logic [14:0] E_EX_XOR  = B_MDR_BUS | B_LOAD_ACC | (15'd3 << 3);
  localparam logic [14:0] E_ST_PREP = B_ACC_BUS | B_LOAD_MDR;
  localparam logic [14:0] E_MEM_WR  = B_CS;

  task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: let inputs settle, compare outputs, advance past the edge
  task automatic cyc(input string tag, input logic [14:0] exp);
    #1;
    chk(tag, outs, exp);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      total++;
      assert ($countones({sif.PC_bus, sif.Addr_bus, sif.ACC_bus, sif.MDR_bus,
                          sif.CS & sif.R_NW}) <= 1) else begin
        bad++;
        $error("FAIL bus_excl observed=%h expected=at_most_one", outs);
      end
      total++;
      assert (!(sif.R_NW && !sif.CS)) else begin
        bad++;
        $error("FAIL rnw_without_cs observed=%h expected=R_NW_0", outs);
      end
      total++;
      assert (sif.ALU_op == 2'b00 || sif.load_ACC) else begin
        bad++;
        $error("FAIL alu_op_outside_exec observed=%h expected=ALU_op_00", outs);
      end
    end
  end

  initial begin
    total         = 0;
    bad           = 0;
    reset         = 1'b1;
    sif.start     = 1'b0;
    sif.op        = 3'b000;
    sif.z_flag    = 1'b0;
    sif.mem_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_hold", outs, E_NONE);
    reset = 1'b0;
    cyc("rst_release", E_NONE);

    // LOAD
    sif.start = 1'b1;
    cyc("idle_start", E_NONE);
    sif.start = 1'b0;
    cyc("ld_f0", E_F0);
    cyc("ld_f1", E_F1_RDY);
    cyc("ld_dec", E_DEC_MEM);
    cyc("ld_rd", E_RD_RDY);
    cyc("ld_ex", E_EX_LOAD);

    // SUB with wait-states, start while running, op changed after DECODE
    sif.op    = 3'b011;
    sif.start = 1'b1;
    cyc("sb_f0", E_F0);
    sif.start     = 1'b0;
    sif.mem_ready = 1'b0;
    cyc("sb_f1_w0", E_RD_WAIT);
    cyc("sb_f1_w1", E_RD_WAIT);
    cyc("sb_f1_w2", E_RD_WAIT);
    sif.mem_ready = 1'b1;
    cyc("sb_f1_rdy", E_F1_RDY);
    sif.mem_ready = 1'b0;
    cyc("sb_dec", E_DEC_MEM);
    cyc("sb_rd_w0", E_RD_WAIT);
    cyc("sb_rd_w1", E_RD_WAIT);
    sif.mem_ready = 1'b1;
    cyc("sb_rd_rdy", E_RD_RDY);
    sif.op = 3'b000;
    cyc("sb_ex", E_EX_SUB);

    // STORE with one write wait-state
    sif.op = 3'b001;
    cyc("st_f0", E_F0);
    cyc("st_f1", E_F1_RDY);
    cyc("st_dec", E_DEC_MEM);
    cyc("st_prep", E_ST_PREP);
    sif.mem_ready = 1'b0;
    cyc("st_wr_wait", E_MEM_WR);
    sif.mem_ready = 1'b1;
    cyc("st_wr", E_MEM_WR);

    // BNE taken, BNE not taken, JUMP
    sif.op     = 3'b100;
    sif.z_flag = 1'b0;
    cyc("bne0_f0", E_F0);
    cyc("bne0_f1", E_F1_RDY);
    cyc("bne0_dec", E_DEC_JMP);
    sif.z_flag = 1'b1;
    cyc("bne1_f0", E_F0);
    cyc("bne1_f1", E_F1_RDY);
    cyc("bne1_dec", E_NONE);
    sif.op = 3'b101;
    cyc("jmp_f0", E_F0);
    cyc("jmp_f1", E_F1_RDY);
    cyc("jmp_dec", E_DEC_JMP);

    // ADD and XOR
    sif.op = 3'b010;
    cyc("add_f0", E_F0);
    cyc("add_f1", E_F1_RDY);
    cyc("add_dec", E_DEC_MEM);
    cyc("add_rd", E_RD_RDY);
    cyc("add_ex", E_EX_ADD);
    sif.op = 3'b110;
    cyc("xor_f0", E_F0);
    cyc("xor_f1", E_F1_RDY);
    cyc("xor_dec", E_DEC_MEM);
    cyc("xor_rd", E_RD_RDY);
    cyc("xor_ex", E_EX_XOR);

    // HALT, start ignored, async reset clears it
    sif.op = 3'b111;
    cyc("hlt_f0", E_F0);
    cyc("hlt_f1", E_F1_RDY);
    cyc("hlt_dec", E_NONE);
    sif.start = 1'b1;
    for (int i = 0; i < 20; i++) cyc("hlt_hold", B_HALTED);
    reset = 1'b1;
    #1;
    chk("hlt_async_rst", outs, E_NONE);
    @(posedge clock);
    #1;
    reset     = 1'b0;
    sif.start = 1'b0;
    cyc("hlt_post_idle", E_NONE);

    // Reset in the middle of a stalled write
    sif.start = 1'b1;
    cyc("wr_idle", E_NONE);
    sif.start = 1'b0;
    sif.op    = 3'b001;
    cyc("wr_f0", E_F0);
    cyc("wr_f1", E_F1_RDY);
    cyc("wr_dec", E_DEC_MEM);
    cyc("wr_prep", E_ST_PREP);
    sif.mem_ready = 1'b0;
    cyc("wr_wait0", E_MEM_WR);
    #1;
    chk("wr_wait1", outs, E_MEM_WR);
    reset = 1'b1;
    #1;
    chk("wr_async_rst", outs, E_NONE);
    @(posedge clock);
    #1;
    reset         = 1'b0;
    sif.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) cyc("wr_no_resume", E_NONE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
